// File: rtl/pong_pkg.sv
// pong_pkg: game state encodings, screen/ball geometry defaults and a
// saturating score helper shared by the game sequencer and the LED logic.
package pong_pkg;

    // Encodings are visible on the state port and reused by the LED logic
    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_state_t;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_BALL_SIZE   = 8;
    localparam int DEF_PADDLE_W    = 10;
    localparam int DEF_PADDLE_H    = 50;
    localparam int DEF_P1_X        = 20;
    localparam int DEF_P2_X        = 610;
    localparam int DEF_WIN_SCORE   = 10;
    localparam int DEF_SERVE_DELAY = 60;
    localparam int DEF_SPEED_INIT  = 2;
    localparam int DEF_SPEED_MAX   = 6;

    // Score + 1, held at the winning score once reached
    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_paddle_hit.sv
// pong_paddle_hit: combinational overlap test between the ball's next
// position and one paddle. The left paddle counts touching its right face
// as a hit; the right paddle (RIGHT_SIDE=1) counts touching its left face.
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter int BALL_SIZE  = DEF_BALL_SIZE,
    parameter int PADDLE_W   = DEF_PADDLE_W,
    parameter int PADDLE_H   = DEF_PADDLE_H,
    parameter bit RIGHT_SIDE = 1'b0
) (
    input  logic signed [11:0] nx,
    input  logic signed [11:0] ny,
    input  logic        [9:0]  paddle_x,
    input  logic        [9:0]  paddle_y,
    output logic               hit
);

    localparam logic signed [11:0] BS = 12'(BALL_SIZE);
    localparam logic signed [11:0] PW = 12'(PADDLE_W);
    localparam logic signed [11:0] PH = 12'(PADDLE_H);

    logic signed [11:0] px, py;
    logic               x_ovl, y_ovl;

    assign px = $signed({2'b00, paddle_x});
    assign py = $signed({2'b00, paddle_y});

    generate
        if (RIGHT_SIDE) begin : g_right
            assign x_ovl = (nx + BS >= px) && (nx < px + PW);
        end else begin : g_left
            assign x_ovl = (nx <= px + PW) && (nx + BS > px);
        end
    endgenerate

    assign y_ovl = (ny + BS > py) && (ny < py + PH);
    assign hit   = x_ovl && y_ovl;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game sequencer. Owns the game FSM, ball motion,
// paddle/wall collision and scoring; everything advances on frame_tick.
// Optional feature macro: PONG_SPEEDUP_EN (paddle hits speed the ball up
// to SPEED_MAX; without it the speed is fixed at SPEED_INIT).
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int PADDLE_W    = DEF_PADDLE_W,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int P1_X        = DEF_P1_X,
    parameter int P2_X        = DEF_P2_X,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SERVE_DELAY = DEF_SERVE_DELAY,
    parameter int SPEED_INIT  = DEF_SPEED_INIT
`ifdef PONG_SPEEDUP_EN
   ,parameter int SPEED_MAX   = DEF_SPEED_MAX
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [9:0] p1_pos,
    input  logic [9:0] p2_pos,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] state,
    output logic       scored
);

    localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [9:0]         X_CTR  = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]         Y_CTR  = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]         P1_XV  = 10'(P1_X);
    localparam logic [9:0]         P2_XV  = 10'(P2_X);
    localparam logic [9:0]         P1_RET = 10'(P1_X + PADDLE_W);
    localparam logic [9:0]         P2_RET = 10'(P2_X - BALL_SIZE);
    localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

    game_state_t        st;
    logic               dx_neg, dy_neg;             // 1 = moving left / up
    logic               serve_dx_neg, serve_dy_neg; // direction for the next serve
    logic [CW-1:0]      serve_cnt;
    logic [3:0]         speed;

    logic signed [11:0] cur_x, cur_y, spd, nx, ny;
    logic               p1_hit_raw, p2_hit_raw, p1_hit, p2_hit;
    logic               miss_l, miss_r, point_wins, serve_go;
    logic [3:0]         p1_inc, p2_inc;
    logic [9:0]         x_next, y_next;
    logic               dx_next, dy_next;

    assign state = st;

    // Next position in 12-bit signed so a step past either edge is visible
    assign cur_x = $signed({2'b00, ball_x});
    assign cur_y = $signed({2'b00, ball_y});
    assign spd   = $signed({8'd0, speed});
    assign nx    = dx_neg ? cur_x - spd : cur_x + spd;
    assign ny    = dy_neg ? cur_y - spd : cur_y + spd;

    pong_paddle_hit #(
        .BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .RIGHT_SIDE(1'b0)
    ) u_hit_p1 (
        .nx(nx), .ny(ny), .paddle_x(P1_XV), .paddle_y(p1_pos), .hit(p1_hit_raw)
    );

    pong_paddle_hit #(
        .BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .RIGHT_SIDE(1'b1)
    ) u_hit_p2 (
        .nx(nx), .ny(ny), .paddle_x(P2_XV), .paddle_y(p2_pos), .hit(p2_hit_raw)
    );

    // A paddle only counts when the ball is travelling towards it
    assign p1_hit = dx_neg && p1_hit_raw;
    assign p2_hit = !dx_neg && p2_hit_raw;

    // Misses rank below paddle hits
    assign miss_l = !p1_hit && !p2_hit && (nx < 12'sd0);
    assign miss_r = !p1_hit && !p2_hit && (nx > X_MAX);

    assign p1_inc     = sat_inc(p1_score, WIN);
    assign p2_inc     = sat_inc(p2_score, WIN);
    assign point_wins = miss_r ? (p1_inc == WIN) : (p2_inc == WIN);
    assign serve_go   = (serve_cnt == CW'(SERVE_DELAY - 1));

    // X resolution: paddle return clamps to the paddle face and flips dx
    always_comb begin
        x_next  = nx[9:0];
        dx_next = dx_neg;
        if (p1_hit) begin
            x_next  = P1_RET;
            dx_next = 1'b0;
        end else if (p2_hit) begin
            x_next  = P2_RET;
            dx_next = 1'b1;
        end
    end

    // Y resolution: clamp to the wall and reflect, independent of X
    always_comb begin
        y_next  = ny[9:0];
        dy_next = dy_neg;
        if (ny <= 12'sd0) begin
            y_next  = '0;
            dy_next = 1'b0;
        end else if (ny >= Y_MAX) begin
            y_next  = Y_MAX[9:0];
            dy_next = 1'b1;
        end
    end

    // Game FSM, ball motion and scoring; all moves happen on frame_tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= QI;
            ball_x       <= X_CTR;
            ball_y       <= Y_CTR;
            dx_neg       <= 1'b0;
            dy_neg       <= 1'b0;
            serve_dx_neg <= 1'b0;
            serve_dy_neg <= 1'b0;
            serve_cnt    <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            scored       <= 1'b0;
        end else begin
            scored <= 1'b0;
            if (frame_tick) begin
                case (st)
                    QI: if (start) begin
                        st           <= QGAME_1;
                        p1_score     <= '0;
                        p2_score     <= '0;
                        ball_x       <= X_CTR;
                        ball_y       <= Y_CTR;
                        serve_cnt    <= '0;
                        serve_dx_neg <= 1'b0;
                        serve_dy_neg <= 1'b0;
                    end
                    QGAME_1: if (!start) begin
                        st <= QI;
                    end else if (serve_go) begin
                        // Launch; the vertical direction alternates serve to serve
                        st           <= QGAME_2;
                        dx_neg       <= serve_dx_neg;
                        dy_neg       <= serve_dy_neg;
                        serve_dy_neg <= ~serve_dy_neg;
                    end else begin
                        serve_cnt <= serve_cnt + 1'b1;
                    end
                    QGAME_2: if (!start) begin
                        st <= QI;
                    end else if (miss_l || miss_r) begin
                        scored <= 1'b1;
                        // Next serve heads towards the player who just scored
                        if (miss_r) begin
                            p1_score     <= p1_inc;
                            serve_dx_neg <= 1'b1;
                        end else begin
                            p2_score     <= p2_inc;
                            serve_dx_neg <= 1'b0;
                        end
                        if (point_wins) begin
                            st <= QDONE;
                        end else begin
                            st        <= QGAME_1;
                            serve_cnt <= '0;
                            ball_x    <= X_CTR;
                            ball_y    <= Y_CTR;
                        end
                    end else begin
                        ball_x <= x_next;
                        dx_neg <= dx_next;
                        ball_y <= y_next;
                        dy_neg <= dy_next;
                    end
                    QDONE: if (!start) st <= QI;
                    default: st <= QI;
                endcase
            end
        end
    end

`ifdef PONG_SPEEDUP_EN
    // Speed: back to the initial value on each serve, +1 per paddle return up to the cap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed <= 4'(SPEED_INIT);
        end else if (frame_tick && start) begin
            if (st == QGAME_1 && serve_go)
                speed <= 4'(SPEED_INIT);
            else if (st == QGAME_2 && (p1_hit || p2_hit) && speed < 4'(SPEED_MAX))
                speed <= speed + 4'd1;
        end
    end
`else
    assign speed = 4'(SPEED_INIT);
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed rally scenarios with hand-computed
// waypoints, plus an integer game model compared on every negedge.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start, frame_tick;
    logic [9:0] p1_pos, p2_pos;
    logic [9:0] ball_x, ball_y;
    logic [3:0] p1_score, p2_score;
    logic [1:0] state;
    logic       scored;

    int errors = 0;
    int checks = 0;
    bit dodge  = 1'b0;
    bit cmp_en = 1'b0;

`ifdef PONG_SPEEDUP_EN
    localparam int HIT_SPD = 3;
`else
    localparam int HIT_SPD = 2;
`endif

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .p1_pos(p1_pos), .p2_pos(p2_pos), .ball_x(ball_x), .ball_y(ball_y),
        .p1_score(p1_score), .p2_score(p2_score), .state(state), .scored(scored)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- game model (plain integers) ----------------
    int m_state, m_x, m_y, m_dx, m_dy, m_spd, m_s1, m_s2, m_ticks, m_sdx, m_sdy, m_scored;

    task automatic m_reset();
        m_state = 0; m_x = 316; m_y = 236; m_dx = 1; m_dy = 1; m_spd = 2;
        m_s1 = 0; m_s2 = 0; m_ticks = 0; m_sdx = 1; m_sdy = 1; m_scored = 0;
    endtask

    task automatic m_point(input int who);
        int s;
        m_scored = 1;
        if (who == 1) begin
            m_s1 = (m_s1 < 10) ? m_s1 + 1 : 10; s = m_s1; m_sdx = -1;
        end else begin
            m_s2 = (m_s2 < 10) ? m_s2 + 1 : 10; s = m_s2; m_sdx = 1;
        end
        if (s == 10) m_state = 3;
        else begin
            m_state = 1; m_ticks = 0; m_x = 316; m_y = 236;
        end
    endtask

    task automatic m_tick();
        int nx, ny, p1, p2;
        bit h1, h2;
        p1 = p1_pos; p2 = p2_pos;
        case (m_state)
            0: if (start) begin
                m_state = 1; m_s1 = 0; m_s2 = 0; m_x = 316; m_y = 236;
                m_ticks = 0; m_sdx = 1; m_sdy = 1;
            end
            1: if (!start) m_state = 0;
               else begin
                   m_ticks++;
                   if (m_ticks == 60) begin
                       m_state = 2; m_dx = m_sdx; m_dy = m_sdy; m_sdy = -m_sdy; m_spd = 2;
                   end
               end
            2: if (!start) m_state = 0;
               else begin
                   nx = m_x + m_dx * m_spd;
                   ny = m_y + m_dy * m_spd;
                   h1 = (m_dx < 0) && (nx <= 30) && (nx + 8 > 20) && (ny + 8 > p1) && (ny < p1 + 50);
                   h2 = (m_dx > 0) && (nx + 8 >= 610) && (nx < 620) && (ny + 8 > p2) && (ny < p2 + 50);
                   if (!h1 && !h2 && nx < 0) m_point(2);
                   else if (!h1 && !h2 && nx > 632) m_point(1);
                   else begin
                       if (h1 || h2) begin
                           m_x = h1 ? 30 : 602;
                           m_dx = -m_dx;
`ifdef PONG_SPEEDUP_EN
                           if (m_spd < 6) m_spd++;
`endif
                       end else m_x = nx;
                       if (ny <= 0) begin m_y = 0; m_dy = 1; end
                       else if (ny >= 472) begin m_y = 472; m_dy = -1; end
                       else m_y = ny;
                   end
               end
            default: if (!start) m_state = 0;
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else begin
            m_scored = 0;
            if (frame_tick) m_tick();
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_state", int'(state), m_state);
            chk("cyc_ball_x", int'(ball_x), m_x);
            chk("cyc_ball_y", int'(ball_y), m_y);
            chk("cyc_p1_score", int'(p1_score), m_s1);
            chk("cyc_p2_score", int'(p2_score), m_s2);
            chk("cyc_scored", int'(scored), m_scored);
        end
    end

    // One frame tick: a quiet clock, then a clock with frame_tick high
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dodge) begin
                p1_pos = (m_y < 240) ? 10'd430 : 10'd0;
                p2_pos = (m_y < 240) ? 10'd430 : 10'd0;
            end
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic chk_ball(input string name, input int x, input int y);
        chk({name, "_x"}, int'(ball_x), x);
        chk({name, "_y"}, int'(ball_y), y);
    endtask

    initial begin
        int n;
        start = 1'b0; frame_tick = 1'b0; p1_pos = 10'd40; p2_pos = 10'd0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk_ball("rst_ball", 316, 236);
        chk("rst_p1", int'(p1_score), 0);
        chk("rst_p2", int'(p2_score), 0);
        chk("rst_scored", int'(scored), 0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Start and serve countdown
        start = 1'b1;
        tick(1);
        chk("start_state", int'(state), 1);
        chk_ball("start_ball", 316, 236);
        tick(59);
        chk("serve59_state", int'(state), 1);
        tick(1);
        chk("serve60_state", int'(state), 2);
        chk_ball("serve60_ball", 316, 236);
        tick(1);
        chk_ball("first_move", 318, 238);

        // Rightward run: bottom wall, then P2 (at top) misses
        tick(117);
        chk_ball("bottom_wall", 552, 472);
        tick(1);
        chk_ball("bottom_after", 554, 470);
        tick(40);
        chk("pt1_p1", int'(p1_score), 1);
        chk("pt1_p2", int'(p2_score), 0);
        chk("pt1_scored", int'(scored), 1);
        chk("pt1_state", int'(state), 1);
        chk_ball("pt1_ball", 316, 236);
        @(negedge clk);
        chk("pt1_scored_off", int'(scored), 0);

        // Second serve goes left with dy flipped; top wall, then P1 returns
        tick(60);
        chk("serve2_state", int'(state), 2);
        tick(1);
        chk_ball("serve2_move", 314, 234);
        tick(117);
        chk_ball("top_wall", 80, 0);
        tick(1);
        chk_ball("top_after", 78, 2);
        tick(24);
        chk_ball("p1_hit", 30, 50);
        chk("p1_hit_state", int'(state), 2);
        chk("p1_hit_p1", int'(p1_score), 1);
        tick(1);
        chk_ball("p1_return", 30 + HIT_SPD, 50 + HIT_SPD);

        // Paddles dodge from here on: points alternate until P1 reaches 10
        dodge = 1'b1;
        n = 0;
        while (state != 2'b11 && n < 15000) begin
            tick(1);
            n++;
        end
        chk("done_state", int'(state), 3);
        chk("done_p1", int'(p1_score), 10);
        chk("done_p2", int'(p2_score), 8);
        tick(3);
        chk("done_hold_state", int'(state), 3);
        start = 1'b0;
        tick(1);
        chk("idle_state", int'(state), 0);
        chk("idle_p1", int'(p1_score), 10);
        chk("idle_p2", int'(p2_score), 8);

        // Restart clears scores; start=0 mid-play stops without moving
        start = 1'b1;
        tick(1);
        chk("restart_state", int'(state), 1);
        chk("restart_p1", int'(p1_score), 0);
        tick(65);
        start = 1'b0;
        tick(1);
        chk("stop_state", int'(state), 0);

        // Asynchronous reset in the middle of play
        start = 1'b1;
        tick(71);
        chk("pre_rst_state", int'(state), 2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk_ball("async_ball", 316, 236);
        chk("async_p1", int'(p1_score), 0);
        chk("async_scored", int'(scored), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
